cnn_div_seq_25s_10s: RTL and testbench
======================================

Name: cnn_div_seq_25s_10s

Overview:
- Multi-cycle signed divider; the inverse of the 14s x 10s -> 25s product path in the conv layers.
- Takes a 25-bit signed accumulator/product and a 10-bit signed scale divisor.
- Returns a saturated 14-bit signed quotient plus a 10-bit signed remainder, using C-style truncation toward zero.
- Sits between the conv accumulator and the requantize/activation stage, behind a valid/ready handshake.

Parameters:
- DIVIDEND_W, 25, dividend width (signed)
- DIVISOR_W, 10, divisor width (signed)
- QUOT_W, 14, output quotient width (signed, saturated)

Ports:
- ap_clk  input  1  clock; all state on rising edge
- ap_rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  25  signed dividend
- divisor  input  10  signed divisor
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- quotient  output  14  signed quotient, saturated
- remainder  output  10  signed remainder, sign of dividend
- ovf  output  1  quotient saturated
- div_zero  output  1  divisor was 0

Behaviour:
- Reset (async, ap_rst_n=0): state=IDLE; in_ready=0 while in reset; out_valid=0; quotient=0; remainder=0; ovf=0; div_zero=0; internal registers cleared.
- After reset release, in_ready=1 on the first cycle in IDLE.
- Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge N: latch |dividend| (25-bit unsigned; -2^24 -> 2^24), |divisor| (10-bit unsigned), sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - If divisor==0: go to DONE. Outputs: quotient = 8191 if dividend>=0, else -8192; remainder=0; div_zero=1; ovf=0. out_valid=1 after edge N+1.
  - Otherwise: iteration counter=24, partial remainder=0, go to CALC.
- CALC: restoring division, one quotient bit per cycle, MSB first.
  - Shift {rem, dvd} left by 1.
  - If rem >= |divisor|, subtract |divisor| and set the quotient bit.
  - Remainder register is 11 bits to hold the pre-subtract value.
  - Exactly 25 cycles; counter decrements; leave to FIX when counter==0 is processed.
- FIX (1 cycle):
  - Apply signs: q = sign_q ? -qmag : qmag; r = sign_r ? -rmag : rmag.
  - Saturation: if q > 8191, quotient=8191; if q < -8192, quotient=-8192. In both cases ovf=1 and remainder=0.
  - Else quotient=q[13:0], remainder=r[9:0], ovf=0. div_zero=0.
  - Go to DONE.
- Latency, accept edge N: outputs registered at edge N+26; out_valid=1 in the following cycle. Divide-by-zero path latency is 1.
- DONE:
  - out_valid=1; in_ready=0.
  - Outputs are stable until out_valid&out_ready.
  - On handshake: out_valid=0 next cycle; go to IDLE. in_ready=1 in the following cycle, so there is no same-cycle bypass.
  - out_ready held low stalls indefinitely with outputs unchanged.
- in_ready=0 in CALC, FIX and DONE. Operand changes while busy are ignored.
- Remainder magnitude is always < |divisor| <= 512, so a non-saturated remainder always fits 10-bit signed.
- Identity: quotient*divisor + remainder == dividend whenever ovf=0 and div_zero=0.

Test Plan:
- Positive and negative operands: 1000/7 -> quotient=142, remainder=6, ovf=0, out_valid exactly 26 cycles after accept. -1000/7 -> -142, -6. 1000/-7 -> -142, 6.
- Saturation: 100000/3 -> quotient=8191, ovf=1, remainder=0. -16777216/1 -> quotient=-8192, ovf=1. -8192/1 -> -8192, ovf=0. -16777216/-512 = 32768 -> 8191, ovf=1.
- Divide by zero: 5/0 -> quotient=8191, div_zero=1, out_valid one cycle after accept. -5/0 -> quotient=-8192, div_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0. Then pulse out_ready -> out_valid drops next cycle; in_ready=1 the cycle after.
- Reset mid-CALC: drop ap_rst_n at cycle 12 of 300/-4 -> out_valid=0 and all outputs 0 immediately. Release, send 300/-4 -> -75, 0, with no stale result.
- Random: 2000 random operand pairs with random out_ready -> match C truncating division with saturation, and the identity check holds for every non-saturated result.

Source files
------------

// File: rtl/cnn_div_seq_25s_10s.sv
// Multi-cycle signed restoring divider: 25-bit signed dividend / 10-bit signed divisor,
// saturated 14-bit signed quotient and 10-bit signed remainder, truncating toward zero.
module cnn_div_seq_25s_10s #(
  parameter int unsigned DIVIDEND_W = 25,
  parameter int unsigned DIVISOR_W  = 10,
  parameter int unsigned QUOT_W     = 14
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOT_W-1:0]     quotient,
  output logic signed [DIVISOR_W-1:0]  remainder,
  output logic                         ovf,
  output logic                         div_zero
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
  localparam int unsigned REM_W = DIVISOR_W + 1;

  localparam logic [DIVIDEND_W-1:0] QMAG_POS = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] QMAG_NEG = DIVIDEND_W'(1 << (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]     QSAT_POS = {1'b0, {(QUOT_W - 1){1'b1}}};
  localparam logic [QUOT_W-1:0]     QSAT_NEG = {1'b1, {(QUOT_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state, state_nx;
  logic [DIVIDEND_W-1:0]   dvd, dvd_nx;
  logic [DIVISOR_W-1:0]    dsr, dsr_nx;
  logic [DIVISOR_W-1:0]    rem, rem_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic                    sign_q, sign_q_nx;
  logic                    sign_r, sign_r_nx;
  logic                    dz, dz_nx;
  logic                    in_ready_nx, out_valid_nx, ovf_nx, div_zero_nx;
  logic [QUOT_W-1:0]       quotient_nx;
  logic [DIVISOR_W-1:0]    remainder_nx;

  logic [REM_W-1:0]        rem_shift_c;
  logic [DIVIDEND_W-1:0]   qneg_c;
  logic [DIVISOR_W-1:0]    rneg_c;

  // State and datapath registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      dvd       <= '0;
      dsr       <= '0;
      rem       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dz        <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state     <= state_nx;
      dvd       <= dvd_nx;
      dsr       <= dsr_nx;
      rem       <= rem_nx;
      cnt       <= cnt_nx;
      sign_q    <= sign_q_nx;
      sign_r    <= sign_r_nx;
      dz        <= dz_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
      quotient  <= quotient_nx;
      remainder <= remainder_nx;
      ovf       <= ovf_nx;
      div_zero  <= div_zero_nx;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_nx     = state;
    dvd_nx       = dvd;
    dsr_nx       = dsr;
    rem_nx       = rem;
    cnt_nx       = cnt;
    sign_q_nx    = sign_q;
    sign_r_nx    = sign_r;
    dz_nx        = dz;
    out_valid_nx = out_valid;
    quotient_nx  = quotient;
    remainder_nx = remainder;
    ovf_nx       = ovf;
    div_zero_nx  = div_zero;

    rem_shift_c  = {rem, dvd[DIVIDEND_W-1]};
    qneg_c       = DIVIDEND_W'(0) - dvd;
    rneg_c       = DIVISOR_W'(0) - rem;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvd_nx    = dividend[DIVIDEND_W-1] ? DIVIDEND_W'(DIVIDEND_W'(0) - dividend)
                                             : DIVIDEND_W'(dividend);
          dsr_nx    = divisor[DIVISOR_W-1] ? DIVISOR_W'(DIVISOR_W'(0) - divisor)
                                           : DIVISOR_W'(divisor);
          sign_q_nx = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          sign_r_nx = dividend[DIVIDEND_W-1];
          rem_nx    = '0;
          cnt_nx    = CNT_W'(DIVIDEND_W - 1);
          dz_nx     = (divisor == '0);
          // A zero divisor skips iteration; FIX formats the saturated result.
          state_nx  = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (rem_shift_c >= {1'b0, dsr}) begin
          rem_nx = DIVISOR_W'(rem_shift_c - {1'b0, dsr});
          dvd_nx = {dvd[DIVIDEND_W-2:0], 1'b1};
        end else begin
          rem_nx = rem_shift_c[DIVISOR_W-1:0];
          dvd_nx = {dvd[DIVIDEND_W-2:0], 1'b0};
        end
        cnt_nx = cnt - 1'b1;
        if (cnt == '0) state_nx = FIX;
      end
      FIX: begin
        out_valid_nx = 1'b1;
        div_zero_nx  = dz;
        ovf_nx       = 1'b0;
        remainder_nx = '0;
        if (dz) begin
          quotient_nx = sign_r ? QSAT_NEG : QSAT_POS;
        end else if (!sign_q && (dvd > QMAG_POS)) begin
          quotient_nx = QSAT_POS;
          ovf_nx      = 1'b1;
        end else if (sign_q && (dvd > QMAG_NEG)) begin
          quotient_nx = QSAT_NEG;
          ovf_nx      = 1'b1;
        end else begin
          quotient_nx  = sign_q ? qneg_c[QUOT_W-1:0] : dvd[QUOT_W-1:0];
          remainder_nx = sign_r ? rneg_c : rem;
        end
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    in_ready_nx = (state_nx == IDLE);
  end

endmodule

// File: tb/tb_cnn_div_seq_25s_10s.sv
// Directed and random self-checking bench for the sequential signed divider.
module tb_cnn_div_seq_25s_10s;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [24:0] dividend = '0;
  logic signed [9:0]  divisor = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [13:0] quotient;
  logic signed [9:0]  remainder;
  logic               ovf;
  logic               div_zero;

  int n_total = 0;
  int n_bad   = 0;

  cnn_div_seq_25s_10s dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .div_zero  (div_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Accept one operand pair and count edges until out_valid rises.
  task automatic send(input int a, input int b, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) chk("in_ready_wait", 0, 1);
    in_valid = 1'b1;
    dividend = 25'(a);
    divisor  = 10'(b);
    tick();
    in_valid = 1'b0;
    dividend = 25'(~a);
    divisor  = 10'(~b);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_valid_wait", 0, 1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int a, input int b, input int eq,
                            input int er, input int eovf, input int edz, input int elat);
    int lat;
    send(a, b, lat);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".ovf"}, ovf, eovf);
    chk({tag, ".dz"}, div_zero, edz);
    release_out();
    chk({tag, ".vld_drop"}, out_valid, 0);
  endtask

  initial begin
    int lat, hq, hr;

    // Reset state
    #2;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.q", quotient, 0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    chk("post_rst.in_ready", in_ready, 1);

    // Sign handling and latency
    expect_res("p_p", 1000, 7, 142, 6, 0, 0, 26);
    expect_res("n_p", -1000, 7, -142, -6, 0, 0, 26);
    expect_res("p_n", 1000, -7, -142, 6, 0, 0, 26);
    expect_res("n_n", -1000, -7, 142, -6, 0, 0, 26);

    // Saturation boundaries
    expect_res("sat_p", 100000, 3, 8191, 0, 1, 0, 26);
    expect_res("sat_min", -16777216, 1, -8192, 0, 1, 0, 26);
    expect_res("edge_n", -8192, 1, -8192, 0, 0, 0, 26);
    expect_res("edge_p", 8191, 1, 8191, 0, 0, 0, 26);
    expect_res("over_n", -8193, 1, -8192, 0, 1, 0, 26);
    expect_res("over_p", 8192, 1, 8191, 0, 1, 0, 26);
    expect_res("sat_nn", -16777216, -512, 8191, 0, 1, 0, 26);
    expect_res("rem_max", 511, -512, 0, 511, 0, 0, 26);
    expect_res("rem_min", -511, 512, 0, -511, 0, 0, 26);

    // Divide by zero
    expect_res("dz_p", 5, 0, 8191, 0, 0, 1, 1);
    expect_res("dz_n", -5, 0, -8192, 0, 0, 1, 1);

    // Backpressure: outputs frozen while out_ready is low
    send(12345, 10, lat);
    chk("bp.lat", lat, 26);
    hq = quotient;
    hr = remainder;
    chk("bp.q", hq, 1234);
    chk("bp.r", hr, 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp.vld", out_valid, 1);
      chk("bp.in_ready", in_ready, 0);
      chk("bp.q_hold", quotient, 1234);
      chk("bp.r_hold", remainder, 5);
    end
    release_out();
    chk("bp.vld_drop", out_valid, 0);
    tick();
    chk("bp.in_ready_back", in_ready, 1);

    // Reset in the middle of CALC
    in_valid = 1'b1;
    dividend = 25'(300);
    divisor  = 10'(-4);
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst.vld", out_valid, 0);
    chk("mid_rst.q", quotient, 0);
    chk("mid_rst.r", remainder, 0);
    chk("mid_rst.in_ready", in_ready, 0);
    tick();
    ap_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("mid_rst.no_stale", out_valid, 0);
    end
    expect_res("after_rst", 300, -4, -75, 0, 0, 0, 26);

    // Random operands against a truncating-division model
    for (int k = 0; k < 2000; k++) begin
      int a, b, eq, er, eovf, edz, stall;
      case ($urandom_range(0, 2))
        0: a = int'($signed(25'($urandom)));
        1: a = int'($signed(16'($urandom)));
        default: a = int'($signed(12'($urandom)));
      endcase
      b = ($urandom_range(0, 63) == 0) ? 0 : int'($signed(10'($urandom)));
      eovf = 0;
      edz  = 0;
      er   = 0;
      if (b == 0) begin
        edz = 1;
        eq  = (a >= 0) ? 8191 : -8192;
      end else begin
        eq = a / b;
        if (eq > 8191) begin
          eq = 8191;
          eovf = 1;
        end else if (eq < -8192) begin
          eq = -8192;
          eovf = 1;
        end else begin
          er = a % b;
        end
      end
      send(a, b, lat);
      chk("rnd.lat", lat, edz ? 1 : 26);
      chk("rnd.q", quotient, eq);
      chk("rnd.r", remainder, er);
      chk("rnd.ovf", ovf, eovf);
      chk("rnd.dz", div_zero, edz);
      if (!eovf && !edz) chk("rnd.identity", int'(quotient) * b + int'(remainder), a);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        if (out_ready) break;
        chk("rnd.stall_q", quotient, eq);
      end
      out_ready = 1'b0;
      if (out_valid) release_out();
      chk("rnd.vld_drop", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
